// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants, FSM state and operand pair type for cmp_feeder
package cmp_pkg;

    localparam int CMP_DATA_WID = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CMP_DATA_WID-1:0] weight;
        logic [CMP_DATA_WID-1:0] pixel;
    } pair_t;

endpackage

// File: rtl/cmp_feeder_if.sv
// rtl/cmp_feeder_if.sv - control, upstream pair stream and compute-side operand bundle
interface cmp_feeder_if import cmp_pkg::*; #(
    parameter int DATA_WID = CMP_DATA_WID,
    parameter int CNT_WID  = 8
);

    logic                start;
    logic [CNT_WID-1:0]  cfg_len;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] in_weight;
    logic [DATA_WID-1:0] in_pixel;
    logic [DATA_WID-1:0] weight;
    logic [DATA_WID-1:0] pixel;
    logic                wgt_state;
    logic                ifm_state;
    logic                win_last;
    logic                done;
    logic                busy;
    logic [CNT_WID-1:0]  skip_cnt;

    modport master (
        output start, cfg_len, in_valid, in_weight, in_pixel,
        input  in_ready, weight, pixel, wgt_state, ifm_state, win_last, done, busy, skip_cnt
    );

    modport slave (
        input  start, cfg_len, in_valid, in_weight, in_pixel,
        output in_ready, weight, pixel, wgt_state, ifm_state, win_last, done, busy, skip_cnt
    );

endinterface

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - synchronous power-of-two FIFO of operand pairs
module pair_fifo import cmp_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = pair_t
) (
    input  logic clock,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    // One extra pointer bit distinguishes full from empty when the indices match.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    T           mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Advance pointers; reset empties the FIFO by aligning them
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Write the pushed pair into the slot addressed by the write pointer
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cmp_feeder.sv
// rtl/cmp_feeder.sv - windowed operand feeder for the compute unit; CMP_FEEDER_SKIP_STATS_EN enables skip_cnt
module cmp_feeder import cmp_pkg::*; #(
    parameter int DATA_WID   = CMP_DATA_WID,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WID    = 8
) (
    input  logic         clock,
    input  logic         rst,
    cmp_feeder_if.slave  bus
);

    typedef struct packed {
        logic [DATA_WID-1:0] weight;
        logic [DATA_WID-1:0] pixel;
    } fpair_t;

    localparam logic [CNT_WID-1:0] CNT_ONE = 1;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_WID-1:0]  len_q;
    logic [CNT_WID-1:0]  acc_cnt;
    logic [CNT_WID-1:0]  emit_cnt;
    logic                start_acc;
    logic                in_ready_c;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    fpair_t              wr_pair;
    fpair_t              rd_pair;
    logic [DATA_WID-1:0] weight_q;
    logic [DATA_WID-1:0] pixel_q;
    logic                last_q;

    assign start_acc = bus.start && (state == IDLE);
    assign push      = bus.in_valid && in_ready_c;
    assign wr_pair   = {bus.in_weight, bus.in_pixel};

    // FSM state register
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus accept/pop decode; in_ready uses only registered state
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready_c = !fifo_full && (acc_cnt < len_q);
                pop        = !fifo_empty;
                if (last_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch window length and track accepted/emitted pair counts
    always_ff @(posedge clock) begin
        if (rst) begin
            len_q    <= '0;
            acc_cnt  <= '0;
            emit_cnt <= '0;
        end else if (start_acc) begin
            len_q    <= bus.cfg_len;
            acc_cnt  <= '0;
            emit_cnt <= '0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
            if (pop) begin
                emit_cnt <= emit_cnt + CNT_ONE;
            end
        end
    end

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fpair_t)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .wdata (wr_pair),
        .pop   (pop),
        .rdata (rd_pair),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Present each popped pair for one cycle; any cycle without a pop shows zeros
    always_ff @(posedge clock) begin
        if (rst || !pop) begin
            weight_q <= '0;
            pixel_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            weight_q <= rd_pair.weight;
            pixel_q  <= rd_pair.pixel;
            last_q   <= ((emit_cnt + CNT_ONE) == len_q);
        end
    end

`ifdef CMP_FEEDER_SKIP_STATS_EN
    logic [CNT_WID-1:0] skip_q;

    // Count pairs with a zero operand as they are presented, saturating at all-ones
    always_ff @(posedge clock) begin
        if (rst || start_acc) begin
            skip_q <= '0;
        end else if (pop && ((rd_pair.weight == '0) || (rd_pair.pixel == '0)) && (skip_q != '1)) begin
            skip_q <= skip_q + CNT_ONE;
        end
    end

    assign bus.skip_cnt = skip_q;
`else
    assign bus.skip_cnt = '0;
`endif

    // Bubbles carry all-zero operands, so the nonzero flags follow directly from them.
    assign bus.in_ready  = in_ready_c;
    assign bus.weight    = weight_q;
    assign bus.pixel     = pixel_q;
    assign bus.wgt_state = (weight_q != '0);
    assign bus.ifm_state = (pixel_q != '0);
    assign bus.win_last  = last_q;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE);

endmodule
